bfs_controller: RTL and testbench
=================================

Name: bfs_controller

Overview:
- Sequences the 8-bit location queue to run a breadth-first search over a 16x16 maze, from a source cell to a target cell.
- A location is {row[7:4], col[3:0]}.
- The block seeds the queue, dequeues cells, and checks the four neighbours of each cell against maze wall memory and an internal visited map.
- Unvisited open neighbours are enqueued. The block reports found or fail and the number of cells expanded.

Parameters:
- ROW_BITS, 4, row field width of a location.
- COL_BITS, 4, column field width of a location.
- Location width is ROW_BITS+COL_BITS (8). Cell count is 2^(ROW_BITS+COL_BITS) (256).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  begin search; sampled only in IDLE
- src_loc  in  8  source cell; sampled when start is accepted
- tgt_loc  in  8  target cell; sampled when start is accepted
- mem_addr  out  8  maze memory address (combinational read)
- mem_wall  in  1  1 = cell at mem_addr is a wall; valid in the same cycle
- q_enqueue  out  1  queue push strobe
- q_dequeue  out  1  queue pop strobe
- q_loc_in  out  8  location to push
- q_loc_out  in  8  popped location; registered, valid the cycle after q_dequeue
- q_nonempty  in  1  1 = queue holds at least one entry
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at end of search
- found  out  1  sticky: target reached
- fail  out  1  sticky: queue exhausted without reaching target
- expand_cnt  out  9  cells dequeued in the current search

Behaviour:
- Reset (async, any state) forces:
  - state IDLE; visited map all 0.
  - busy, done, found, fail, q_enqueue, q_dequeue = 0.
  - expand_cnt = 0; mem_addr = 0; q_loc_in = 0.
- All outputs other than done/found/fail/expand_cnt are decoded from state, so a reset mid-search drops strobes immediately.
- States and transitions:
  - IDLE:
    - start=1: latch src/tgt, clear found/fail/expand_cnt -> INIT.
    - start=0: stay.
  - INIT:
    - Clear the whole visited map, then set visited[src].
    - Assert q_enqueue with q_loc_in=src -> POP.
    - The source is never wall-checked.
  - POP:
    - q_nonempty=0 -> FAIL.
    - Otherwise assert q_dequeue -> WAIT.
  - WAIT:
    - expand_cnt += 1.
    - q_loc_out==tgt -> FOUND.
    - Otherwise latch cur=q_loc_out, dir=0 -> NEIGH.
  - NEIGH: one direction per cycle.
    - Direction order: 0 up (row-1), 1 right (col+1), 2 down (row+1), 3 left (col-1).
    - Neighbour is out of bounds when row==0/up, col==max/right, row==max/down, or col==0/left. Out-of-bounds neighbours are skipped with no memory access needed; there is no wrap-around.
    - mem_addr = neighbour.
    - If in-bounds, mem_wall==0 and visited[nb]==0: assert q_enqueue with q_loc_in=nb and set visited[nb] in the same cycle.
    - dir==3 -> POP; otherwise dir += 1.
  - FOUND: done=1, found=1 -> IDLE.
  - FAIL: done=1, fail=1 -> IDLE.
- Handshake and strobe rules:
  - q_enqueue and q_dequeue are never asserted in the same cycle.
  - Each cell is enqueued at most once, so at most 256 pushes per search. Queue depth >= 256 is guaranteed and no full signal is used.
- Visited map: 256 x 1-bit registers; written only in INIT and NEIGH.
- start while busy is ignored. src/tgt changes after acceptance are ignored.
- found/fail hold until the next accepted start or reset.
- expand_cnt saturates at 256, which cannot be exceeded.

Test Plan:
- Trivial search: src=tgt=0x00 with an all-open maze, start pulsed.
  - Cycle after edge 1: INIT.
  - done=1 in the cycle after edge 4.
  - found=1, fail=0, expand_cnt=1, exactly one q_enqueue total.
- Adjacent target: src=0x00, tgt=0x01, open maze.
  - Enqueues in order 0x00, 0x01, 0x10.
  - found=1, expand_cnt=2.
  - Up and left of 0x00 produce no q_enqueue.
- Boxed source: src=0x00, tgt=0xFF, walls at 0x01 and 0x10.
  - One dequeue, no further enqueues.
  - done in the cycle after edge 9 from start; fail=1, found=0, expand_cnt=1.
- Full open maze: src=0x00, tgt=0xFF.
  - found=1.
  - No location enqueued twice (scoreboard).
  - expand_cnt <= 256.
- Async reset mid-search: assert rst during NEIGH of the open-maze run.
  - Same cycle: busy, q_enqueue, found, done = 0.
  - A new start then reproduces the trivial-search result exactly (visited cleared).
- Start while busy: pulse start with a different src during a run.
  - Ignored; original search result and expand_cnt unchanged.

Source files
------------

// File: rtl/bfs_controller.sv
// Breadth-first search sequencer over a 2^ROW_BITS x 2^COL_BITS maze.
// Drives an external location queue, reads wall memory and keeps a visited map.
module bfs_controller #(
   parameter int ROW_BITS = 4,
   parameter int COL_BITS = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic [ROW_BITS+COL_BITS-1:0] src_loc,
   input  logic [ROW_BITS+COL_BITS-1:0] tgt_loc,
   output logic [ROW_BITS+COL_BITS-1:0] mem_addr,
   input  logic                         mem_wall,
   output logic                         q_enqueue,
   output logic                         q_dequeue,
   output logic [ROW_BITS+COL_BITS-1:0] q_loc_in,
   input  logic [ROW_BITS+COL_BITS-1:0] q_loc_out,
   input  logic                         q_nonempty,
   output logic                         busy,
   output logic                         done,
   output logic                         found,
   output logic                         fail,
   output logic [ROW_BITS+COL_BITS:0]   expand_cnt
);

   localparam int LOC_W = ROW_BITS + COL_BITS;
   localparam int CELLS = 1 << LOC_W;
   localparam logic [ROW_BITS-1:0] ROW_ONE = {{(ROW_BITS-1){1'b0}}, 1'b1};
   localparam logic [ROW_BITS-1:0] ROW_MAX = {ROW_BITS{1'b1}};
   localparam logic [COL_BITS-1:0] COL_ONE = {{(COL_BITS-1){1'b0}}, 1'b1};
   localparam logic [COL_BITS-1:0] COL_MAX = {COL_BITS{1'b1}};
   localparam logic [LOC_W:0]      CNT_ONE = {{LOC_W{1'b0}}, 1'b1};
   localparam logic [LOC_W:0]      CNT_MAX = CELLS[LOC_W:0];

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_INIT  = 3'd1,
      S_POP   = 3'd2,
      S_WAIT  = 3'd3,
      S_NEIGH = 3'd4,
      S_FOUND = 3'd5,
      S_FAIL  = 3'd6
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [LOC_W-1:0]   r_src;
   logic [LOC_W-1:0]   r_tgt;
   logic [LOC_W-1:0]   r_cur;
   logic [1:0]         r_dir;
   logic [CELLS-1:0]   r_visited;
   logic               r_found;
   logic               r_fail;
   logic [LOC_W:0]     r_expand_cnt;

   logic [ROW_BITS-1:0] w_row;
   logic [COL_BITS-1:0] w_col;
   logic [LOC_W-1:0]    w_nb;
   logic                w_oob;
   logic                w_enq;
   logic                w_deq;
   logic [LOC_W-1:0]    w_loc_in;
   logic [LOC_W-1:0]    w_mem_addr;
   logic                w_set_vis;

   assign w_row = r_cur[LOC_W-1:COL_BITS];
   assign w_col = r_cur[COL_BITS-1:0];

   // Neighbour of the current cell in direction r_dir, with edge detection (no wrap).
   always_comb begin
      w_nb  = r_cur;
      w_oob = 1'b0;
      case (r_dir)
         2'd0: begin
            w_oob = (w_row == {ROW_BITS{1'b0}});
            w_nb  = {w_row - ROW_ONE, w_col};
         end
         2'd1: begin
            w_oob = (w_col == COL_MAX);
            w_nb  = {w_row, w_col + COL_ONE};
         end
         2'd2: begin
            w_oob = (w_row == ROW_MAX);
            w_nb  = {w_row + ROW_ONE, w_col};
         end
         2'd3: begin
            w_oob = (w_col == {COL_BITS{1'b0}});
            w_nb  = {w_row, w_col - COL_ONE};
         end
         default: begin
            w_oob = 1'b1;
            w_nb  = r_cur;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state and state-decoded strobes.
   always_comb begin
      w_state_nxt = r_state;
      w_enq       = 1'b0;
      w_deq       = 1'b0;
      w_loc_in    = {LOC_W{1'b0}};
      w_mem_addr  = {LOC_W{1'b0}};
      w_set_vis   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_state_nxt = S_INIT;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_INIT: begin
            w_enq       = 1'b1;
            w_loc_in    = r_src;
            w_state_nxt = S_POP;
         end
         S_POP: begin
            if (!q_nonempty) begin
               w_state_nxt = S_FAIL;
            end else begin
               w_deq       = 1'b1;
               w_state_nxt = S_WAIT;
            end
         end
         S_WAIT: begin
            if (q_loc_out == r_tgt) begin
               w_state_nxt = S_FOUND;
            end else begin
               w_state_nxt = S_NEIGH;
            end
         end
         S_NEIGH: begin
            w_mem_addr = w_nb;
            if (!w_oob && !mem_wall && !r_visited[w_nb]) begin
               w_enq     = 1'b1;
               w_loc_in  = w_nb;
               w_set_vis = 1'b1;
            end else begin
               w_enq     = 1'b0;
            end
            if (r_dir == 2'd3) begin
               w_state_nxt = S_POP;
            end else begin
               w_state_nxt = S_NEIGH;
            end
         end
         S_FOUND: w_state_nxt = S_IDLE;
         S_FAIL:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Search context, sticky result flags and expansion counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_src        <= {LOC_W{1'b0}};
         r_tgt        <= {LOC_W{1'b0}};
         r_cur        <= {LOC_W{1'b0}};
         r_dir        <= 2'd0;
         r_found      <= 1'b0;
         r_fail       <= 1'b0;
         r_expand_cnt <= {(LOC_W+1){1'b0}};
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_src        <= src_loc;
                  r_tgt        <= tgt_loc;
                  r_found      <= 1'b0;
                  r_fail       <= 1'b0;
                  r_expand_cnt <= {(LOC_W+1){1'b0}};
               end
            end
            S_POP: begin
               if (!q_nonempty) begin
                  r_fail <= 1'b1;
               end
            end
            S_WAIT: begin
               if (r_expand_cnt != CNT_MAX) begin
                  r_expand_cnt <= r_expand_cnt + CNT_ONE;
               end
               if (q_loc_out == r_tgt) begin
                  r_found <= 1'b1;
               end else begin
                  r_cur <= q_loc_out;
                  r_dir <= 2'd0;
               end
            end
            S_NEIGH: r_dir <= r_dir + 2'd1;
            default: ;
         endcase
      end
   end

   // Visited map: cleared and seeded with the source in INIT, marked on enqueue.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_visited <= {CELLS{1'b0}};
      end else if (r_state == S_INIT) begin
         r_visited        <= {CELLS{1'b0}};
         r_visited[r_src] <= 1'b1;
      end else if (w_set_vis) begin
         r_visited[w_nb] <= 1'b1;
      end else begin
         r_visited <= r_visited;
      end
   end

   assign mem_addr   = w_mem_addr;
   assign q_enqueue  = w_enq;
   assign q_dequeue  = w_deq;
   assign q_loc_in   = w_loc_in;
   assign busy       = (r_state != S_IDLE);
   assign done       = (r_state == S_FOUND) || (r_state == S_FAIL);
   assign found      = r_found;
   assign fail       = r_fail;
   assign expand_cnt = r_expand_cnt;

endmodule

// File: tb/tb_bfs_controller.sv
// Directed bench for bfs_controller: behavioural maze memory and FIFO queue,
// enqueue logger, and hand-computed expectations per scenario.
module tb_bfs_controller;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [7:0] src_loc;
   logic [7:0] tgt_loc;
   logic [7:0] mem_addr;
   logic       mem_wall;
   logic       q_enqueue;
   logic       q_dequeue;
   logic [7:0] q_loc_in;
   logic [7:0] q_loc_out;
   logic       q_nonempty;
   logic       busy;
   logic       done;
   logic       found;
   logic       fail;
   logic [8:0] expand_cnt;

   bfs_controller dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .src_loc    (src_loc),
      .tgt_loc    (tgt_loc),
      .mem_addr   (mem_addr),
      .mem_wall   (mem_wall),
      .q_enqueue  (q_enqueue),
      .q_dequeue  (q_dequeue),
      .q_loc_in   (q_loc_in),
      .q_loc_out  (q_loc_out),
      .q_nonempty (q_nonempty),
      .busy       (busy),
      .done       (done),
      .found      (found),
      .fail       (fail),
      .expand_cnt (expand_cnt)
   );

   always #5 clk = ~clk;

   logic [255:0] wall_map;
   assign mem_wall = wall_map[mem_addr];

   // Queue model, flushed by reset or by the bench before each search.
   logic       log_clr;
   logic [7:0] qmem [0:511];
   logic [9:0] q_head;
   logic [9:0] q_tail;
   assign q_nonempty = (q_head != q_tail);

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         q_head    <= 10'd0;
         q_tail    <= 10'd0;
         q_loc_out <= 8'h00;
      end else if (log_clr) begin
         q_head    <= 10'd0;
         q_tail    <= 10'd0;
      end else begin
         if (q_enqueue) begin
            qmem[q_tail[8:0]] <= q_loc_in;
            q_tail            <= q_tail + 10'd1;
         end
         if (q_dequeue) begin
            q_loc_out <= qmem[q_head[8:0]];
            q_head    <= q_head + 10'd1;
         end
      end
   end

   // Strobe logger: order of first pushes, duplicates, pops, overlapping strobes.
   int           enq_cnt;
   int           deq_cnt;
   int           dup_cnt;
   int           both_cnt;
   logic [7:0]   enq_log [0:3];
   logic [255:0] seen;

   always @(posedge clk) begin
      if (log_clr) begin
         enq_cnt  <= 0;
         deq_cnt  <= 0;
         dup_cnt  <= 0;
         both_cnt <= 0;
         seen     <= '0;
      end else begin
         if (q_enqueue) begin
            if (enq_cnt < 4) enq_log[enq_cnt[1:0]] <= q_loc_in;
            if (seen[q_loc_in]) dup_cnt <= dup_cnt + 1;
            seen[q_loc_in] <= 1'b1;
            enq_cnt        <= enq_cnt + 1;
         end
         if (q_dequeue) deq_cnt <= deq_cnt + 1;
         if (q_enqueue && q_dequeue) both_cnt <= both_cnt + 1;
      end
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Flush logs/queue, then pulse start; returns 1ns after the accepting edge.
   task automatic go(input logic [7:0] s, input logic [7:0] t);
      log_clr = 1'b1;
      tick();
      log_clr = 1'b0;
      src_loc = s;
      tgt_loc = t;
      start   = 1'b1;
      tick();
      start   = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int budget);
      int k = 0;
      while (!done && k < budget) begin
         tick();
         k++;
      end
      chk(tag, 32'(done), 32'd1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst      = 1'b1;
      start    = 1'b0;
      src_loc  = 8'h00;
      tgt_loc  = 8'h00;
      log_clr  = 1'b0;
      wall_map = '0;
      #12;
      chk("rst_busy",   32'(busy),       32'd0);
      chk("rst_done",   32'(done),       32'd0);
      chk("rst_found",  32'(found),      32'd0);
      chk("rst_fail",   32'(fail),       32'd0);
      chk("rst_enq",    32'(q_enqueue),  32'd0);
      chk("rst_deq",    32'(q_dequeue),  32'd0);
      chk("rst_cnt",    32'(expand_cnt), 32'd0);
      chk("rst_addr",   32'(mem_addr),   32'd0);
      chk("rst_locin",  32'(q_loc_in),   32'd0);
      rst = 1'b0;

      // Trivial search: src == tgt
      go(8'h00, 8'h00);
      chk("triv_init_busy", 32'(busy),      32'd1);
      chk("triv_init_enq",  32'(q_enqueue), 32'd1);
      chk("triv_init_loc",  32'(q_loc_in),  32'h00);
      tick();
      chk("triv_pop_deq",   32'(q_dequeue), 32'd1);
      tick();
      tick();
      chk("triv_done",      32'(done),       32'd1);
      chk("triv_found",     32'(found),      32'd1);
      chk("triv_fail",      32'(fail),       32'd0);
      chk("triv_cnt",       32'(expand_cnt), 32'd1);
      tick();
      chk("triv_done_pulse", 32'(done),  32'd0);
      chk("triv_idle",       32'(busy),  32'd0);
      chk("triv_found_hold", 32'(found), 32'd1);
      chk("triv_enq_total",  32'(enq_cnt), 32'd1);

      // Adjacent target
      go(8'h00, 8'h01);
      wait_done("adj_done", 100);
      chk("adj_found",  32'(found),      32'd1);
      chk("adj_cnt",    32'(expand_cnt), 32'd2);
      chk("adj_enqs",   32'(enq_cnt),    32'd3);
      chk("adj_enq0",   32'(enq_log[0]), 32'h00);
      chk("adj_enq1",   32'(enq_log[1]), 32'h01);
      chk("adj_enq2",   32'(enq_log[2]), 32'h10);

      // Boxed source: walls right of and below 0x00
      wall_map[8'h01] = 1'b1;
      wall_map[8'h10] = 1'b1;
      go(8'h00, 8'hFF);
      for (int i = 0; i < 7; i++) tick();
      chk("box_done_early", 32'(done), 32'd0);
      tick();
      chk("box_done",   32'(done),       32'd1);
      chk("box_fail",   32'(fail),       32'd1);
      chk("box_found",  32'(found),      32'd0);
      chk("box_cnt",    32'(expand_cnt), 32'd1);
      chk("box_deqs",   32'(deq_cnt),    32'd1);
      chk("box_enqs",   32'(enq_cnt),    32'd1);
      wall_map = '0;

      // Full open maze: far corner is the last cell dequeued
      go(8'h00, 8'hFF);
      wait_done("open_done", 4000);
      chk("open_found", 32'(found),      32'd1);
      chk("open_fail",  32'(fail),       32'd0);
      chk("open_cnt",   32'(expand_cnt), 32'd256);
      chk("open_enqs",  32'(enq_cnt),    32'd256);
      chk("open_dups",  32'(dup_cnt),    32'd0);
      chk("open_both",  32'(both_cnt),   32'd0);

      // Start while busy is ignored
      go(8'h00, 8'h01);
      src_loc = 8'h55;
      tgt_loc = 8'h55;
      start   = 1'b1;
      tick();
      start   = 1'b0;
      wait_done("busy_done", 100);
      chk("busy_found", 32'(found),      32'd1);
      chk("busy_cnt",   32'(expand_cnt), 32'd2);
      chk("busy_enqs",  32'(enq_cnt),    32'd3);
      chk("busy_enq0",  32'(enq_log[0]), 32'h00);
      chk("busy_enq2",  32'(enq_log[2]), 32'h10);

      // Async reset during NEIGH (right of 0x00 being pushed)
      go(8'h00, 8'hFF);
      for (int i = 0; i < 4; i++) tick();
      chk("mid_pre_enq", 32'(q_enqueue), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      chk("mid_busy",  32'(busy),      32'd0);
      chk("mid_enq",   32'(q_enqueue), 32'd0);
      chk("mid_found", 32'(found),     32'd0);
      chk("mid_done",  32'(done),      32'd0);
      #2;
      rst = 1'b0;
      go(8'h00, 8'h00);
      chk("post_init_enq", 32'(q_enqueue), 32'd1);
      tick();
      tick();
      tick();
      chk("post_done",  32'(done),       32'd1);
      chk("post_found", 32'(found),      32'd1);
      chk("post_fail",  32'(fail),       32'd0);
      chk("post_cnt",   32'(expand_cnt), 32'd1);
      tick();
      chk("post_enqs",  32'(enq_cnt),    32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
